// File: rtl/mmc1_pkg.sv
// mmc1_pkg: shared types and constants for the MMC1 serial register port.
//   reg_sel_e  - target register chosen by CPU A14:A13 on the fifth write
//   mirror_e   - nametable mirroring encoding held in control[1:0]
//   SR_EMPTY   - shift register value with only the marker bit set
//   CTRL_RESET - control value after reset (PRG mode 3, CHR 8K, one-screen low)
//   PRG_MODE_BITS - control bits forced high by a D7 shift reset
package mmc1_pkg;

    typedef enum logic [1:0] {
        REG_CTRL = 2'd0,
        REG_CHR0 = 2'd1,
        REG_CHR1 = 2'd2,
        REG_PRG  = 2'd3
    } reg_sel_e;

    typedef enum logic [1:0] {
        MIR_ONE_LO = 2'd0,
        MIR_ONE_HI = 2'd1,
        MIR_VERT   = 2'd2,
        MIR_HORZ   = 2'd3
    } mirror_e;

    localparam logic [4:0] SR_EMPTY      = 5'b10000;
    localparam logic [4:0] CTRL_RESET    = 5'h0C;
    localparam logic [4:0] PRG_MODE_BITS = 5'h0C;

endpackage

// File: rtl/mmc1_bank_map.sv
// mmc1_bank_map: combinational PRG/CHR/CIRAM address mapping.
// Ports:
//   ctrl       in  5  control register (mirroring, PRG mode, CHR mode)
//   chr0, chr1 in  5  CHR bank registers
//   prg        in  4  PRG bank register, bank bits only
//   cpu_a14    in  1  live CPU A14
//   ppu_a12_10 in  3  live PPU A12:A10
//   prg_a      out 4  PRG ROM A17:A14
//   chr_a      out 5  CHR A16:A12
//   ciram_a10  out 1  nametable select
module mmc1_bank_map
    import mmc1_pkg::*;
(
    input  logic [4:0] ctrl,
    input  logic [4:0] chr0,
    input  logic [4:0] chr1,
    input  logic [3:0] prg,
    input  logic       cpu_a14,
    input  logic [2:0] ppu_a12_10,
    output logic [3:0] prg_a,
    output logic [4:0] chr_a,
    output logic       ciram_a10
);

    logic ppu_a12;
    logic ppu_a11;
    logic ppu_a10;

    assign ppu_a12 = ppu_a12_10[2];
    assign ppu_a11 = ppu_a12_10[1];
    assign ppu_a10 = ppu_a12_10[0];

    always_comb begin
        ciram_a10 = 1'b0;
        case (mirror_e'(ctrl[1:0]))
            MIR_ONE_LO: ciram_a10 = 1'b0;
            MIR_ONE_HI: ciram_a10 = 1'b1;
            MIR_VERT:   ciram_a10 = ppu_a10;
            MIR_HORZ:   ciram_a10 = ppu_a11;
            default:    ciram_a10 = 1'b0;
        endcase
    end

    // Modes 0/1 switch 32K, so bank bit 0 comes from the CPU address.
    // Mode 2 fixes the first bank at $8000; mode 3 fixes the last at $C000.
    always_comb begin
        prg_a = 4'h0;
        case (ctrl[3:2])
            2'b00, 2'b01: prg_a = {prg[3:1], cpu_a14};
            2'b10:        prg_a = cpu_a14 ? prg : 4'h0;
            2'b11:        prg_a = cpu_a14 ? 4'hF : prg;
            default:      prg_a = 4'h0;
        endcase
    end

    // 8K mode ignores chr0[0] and chr1 entirely; 4K mode uses both banks.
    always_comb begin
        chr_a = 5'h00;
        if (ctrl[4])
            chr_a = ppu_a12 ? chr1 : chr0;
        else
            chr_a = {chr0[4:1], ppu_a12};
    end

endmodule

// File: rtl/mmc1_serial_ctrl.sv
// mmc1_serial_ctrl: MMC1 serial register port, clocked implementation.
// Collects D0 over five accepted writes to $8000-$FFFF and commits the
// value into control/CHR0/CHR1/PRG chosen by A14:A13 of the fifth write.
// Optional feature macro: MMC1_CONSEC_WRITE_FILTER_EN drops a write that
// directly follows another write cycle (6502 read-modify-write dummy write).
// Ports:
//   ck, res            clock; synchronous active-high reset
//   cpu_cyc, cpu_wr    end-of-CPU-cycle strobe and its write qualifier
//   cpu_a14_13         register select, used on the fifth write only
//   cpu_d0, cpu_d7     serial data bit; shift-register reset request
//   cpu_a14, ppu_a12_10 live addresses for bank mapping
//   prg_a, chr_a, ciram_a10, wram_dis  mapped outputs
//   reg_wr, reg_sel    registered one-ck commit pulse and its target
module mmc1_serial_ctrl
    import mmc1_pkg::*;
(
    input  logic       ck,
    input  logic       res,
    input  logic       cpu_cyc,
    input  logic       cpu_wr,
    input  logic [1:0] cpu_a14_13,
    input  logic       cpu_d0,
    input  logic       cpu_d7,
    input  logic       cpu_a14,
    input  logic [2:0] ppu_a12_10,
    output logic [3:0] prg_a,
    output logic [4:0] chr_a,
    output logic       ciram_a10,
    output logic       wram_dis,
    output logic       reg_wr,
    output logic [1:0] reg_sel
);

    logic [4:0] sr;
    logic [4:0] ctrl_q;
    logic [4:0] chr0_q;
    logic [4:0] chr1_q;
    logic [4:0] prg_q;
    logic [4:0] shifted;
    logic       accept;

    assign shifted = {cpu_d0, sr[4:1]};

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    logic prev_wr;

    // Tracks every CPU cycle, including writes that were themselves dropped.
    always_ff @(posedge ck) begin
        if (res)
            prev_wr <= 1'b0;
        else if (cpu_cyc)
            prev_wr <= cpu_wr;
    end

    assign accept = cpu_cyc & cpu_wr & ~prev_wr;
`else
    assign accept = cpu_cyc & cpu_wr;
`endif

    always_ff @(posedge ck) begin
        if (res) begin
            sr      <= SR_EMPTY;
            ctrl_q  <= CTRL_RESET;
            chr0_q  <= 5'h00;
            chr1_q  <= 5'h00;
            prg_q   <= 5'h00;
            reg_wr  <= 1'b0;
            reg_sel <= 2'b00;
        end else begin
            reg_wr <= 1'b0;
            if (accept) begin
                if (cpu_d7) begin
                    sr     <= SR_EMPTY;
                    ctrl_q <= ctrl_q | PRG_MODE_BITS;
                end else if (sr[0]) begin
                    // Marker has reached bit 0: this is the fifth bit.
                    sr      <= SR_EMPTY;
                    reg_wr  <= 1'b1;
                    reg_sel <= cpu_a14_13;
                    case (reg_sel_e'(cpu_a14_13))
                        REG_CTRL: ctrl_q <= shifted;
                        REG_CHR0: chr0_q <= shifted;
                        REG_CHR1: chr1_q <= shifted;
                        REG_PRG:  prg_q  <= shifted;
                        default:  ctrl_q <= ctrl_q;
                    endcase
                end else begin
                    sr <= shifted;
                end
            end
        end
    end

    assign wram_dis = prg_q[4];

    mmc1_bank_map u_bank_map (
        .ctrl       (ctrl_q),
        .chr0       (chr0_q),
        .chr1       (chr1_q),
        .prg        (prg_q[3:0]),
        .cpu_a14    (cpu_a14),
        .ppu_a12_10 (ppu_a12_10),
        .prg_a      (prg_a),
        .chr_a      (chr_a),
        .ciram_a10  (ciram_a10)
    );

endmodule

// File: tb/tb_mmc1_serial_ctrl.sv
// tb_mmc1_serial_ctrl: directed bench for mmc1_serial_ctrl with
// hand-computed expectations. Follows MMC1_CONSEC_WRITE_FILTER_EN if defined.
module tb_mmc1_serial_ctrl;

    logic       ck = 1'b0;
    logic       res = 1'b1;
    logic       cpu_cyc = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [1:0] cpu_a14_13 = 2'b00;
    logic       cpu_d0 = 1'b0;
    logic       cpu_d7 = 1'b0;
    logic       cpu_a14 = 1'b0;
    logic [2:0] ppu_a12_10 = 3'b000;
    logic [3:0] prg_a;
    logic [4:0] chr_a;
    logic       ciram_a10;
    logic       wram_dis;
    logic       reg_wr;
    logic [1:0] reg_sel;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    logic [1:0] last_sel = 2'b00;
    int p0;

    mmc1_serial_ctrl dut (
        .ck         (ck),
        .res        (res),
        .cpu_cyc    (cpu_cyc),
        .cpu_wr     (cpu_wr),
        .cpu_a14_13 (cpu_a14_13),
        .cpu_d0     (cpu_d0),
        .cpu_d7     (cpu_d7),
        .cpu_a14    (cpu_a14),
        .ppu_a12_10 (ppu_a12_10),
        .prg_a      (prg_a),
        .chr_a      (chr_a),
        .ciram_a10  (ciram_a10),
        .wram_dis   (wram_dis),
        .reg_wr     (reg_wr),
        .reg_sel    (reg_sel)
    );

    always #5 ck = ~ck;

    always @(negedge ck) begin
        if (reg_wr) begin
            pulse_cnt = pulse_cnt + 1;
            last_sel  = reg_sel;
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge ck);
        res = 1'b1;
        repeat (2) @(negedge ck);
        res = 1'b0;
    endtask

    task automatic wr_cyc(input logic [1:0] sel, input logic d0, input logic d7);
        @(negedge ck);
        cpu_cyc = 1'b1; cpu_wr = 1'b1;
        cpu_a14_13 = sel; cpu_d0 = d0; cpu_d7 = d7;
        @(negedge ck);
        cpu_cyc = 1'b0; cpu_wr = 1'b0; cpu_d7 = 1'b0;
    endtask

    task automatic rd_cyc();
        @(negedge ck);
        cpu_cyc = 1'b1; cpu_wr = 1'b0;
        @(negedge ck);
        cpu_cyc = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic d0, input logic d7);
        wr_cyc(sel, d0, d7);
        rd_cyc();
    endtask

    task automatic load5(input logic [1:0] sel, input logic [4:0] v);
        for (int i = 0; i < 5; i++)
            wr(sel, v[i], 1'b0);
    endtask

    task automatic probe(input logic a14, input logic [2:0] ppu);
        cpu_a14 = a14;
        ppu_a12_10 = ppu;
        #1;
    endtask

    initial begin
        do_reset();

        // Reset state
        probe(1'b1, 3'b100);
        chk("rst_prg_a14", {4'h0, prg_a}, 8'h0F);
        chk("rst_chr_a", {3'h0, chr_a}, 8'h01);
        chk("rst_ciram", {7'h0, ciram_a10}, 8'h00);
        chk("rst_wram", {7'h0, wram_dis}, 8'h00);
        chk("rst_reg_wr", {7'h0, reg_wr}, 8'h00);
        chk("rst_reg_sel", {6'h0, reg_sel}, 8'h00);
        probe(1'b0, 3'b100);
        chk("rst_prg_a14lo", {4'h0, prg_a}, 8'h00);

        // PRG = 05 through $E000
        p0 = pulse_cnt;
        load5(2'd3, 5'h05);
        chk("prg_pulse", pulse_cnt - p0, 8'd1);
        chk("prg_sel", {6'h0, last_sel}, 8'h03);
        probe(1'b0, 3'b000);
        chk("prg_map_lo", {4'h0, prg_a}, 8'h05);
        probe(1'b1, 3'b000);
        chk("prg_map_hi", {4'h0, prg_a}, 8'h0F);

        // control = 12 (CHR 4K, vertical, PRG 32K), chr1 = 1A, chr0 = 07
        load5(2'd0, 5'h12);
        chk("ctrl_sel", {6'h0, last_sel}, 8'h00);
        load5(2'd2, 5'h1A);
        load5(2'd1, 5'h07);
        probe(1'b1, 3'b100);
        chk("chr4k_a12hi", {3'h0, chr_a}, 8'h1A);
        probe(1'b1, 3'b000);
        chk("chr4k_a12lo", {3'h0, chr_a}, 8'h07);
        probe(1'b1, 3'b001);
        chk("vert_a10hi", {7'h0, ciram_a10}, 8'h01);
        probe(1'b1, 3'b010);
        chk("vert_a10lo", {7'h0, ciram_a10}, 8'h00);
        probe(1'b1, 3'b000);
        chk("prg32_hi", {4'h0, prg_a}, 8'h05);
        probe(1'b0, 3'b000);
        chk("prg32_lo", {4'h0, prg_a}, 8'h04);

        // control = 03 (CHR 8K, horizontal)
        load5(2'd0, 5'h03);
        probe(1'b0, 3'b010);
        chk("horz_a11hi", {7'h0, ciram_a10}, 8'h01);
        probe(1'b0, 3'b001);
        chk("horz_a11lo", {7'h0, ciram_a10}, 8'h00);
        probe(1'b0, 3'b100);
        chk("chr8k_a12hi", {3'h0, chr_a}, 8'h07);
        probe(1'b0, 3'b000);
        chk("chr8k_a12lo", {3'h0, chr_a}, 8'h06);

        // D7 reset after three bits: control becomes 0F, sr empty
        p0 = pulse_cnt;
        wr(2'd3, 1'b1, 1'b0);
        wr(2'd3, 1'b1, 1'b0);
        wr(2'd3, 1'b1, 1'b0);
        wr(2'd3, 1'b0, 1'b1);
        chk("d7_no_commit", pulse_cnt - p0, 8'd0);
        probe(1'b0, 3'b010);
        chk("d7_prg_mode3", {4'h0, prg_a}, 8'h05);
        chk("d7_mirror_kept", {7'h0, ciram_a10}, 8'h01);
        probe(1'b1, 3'b010);
        chk("d7_prg_fixed", {4'h0, prg_a}, 8'h0F);
        // PRG = 1B needs a full five writes
        for (int i = 0; i < 4; i++)
            wr(2'd3, (i == 2) ? 1'b0 : 1'b1, 1'b0);
        chk("d7_four_no_commit", pulse_cnt - p0, 8'd0);
        wr(2'd3, 1'b1, 1'b0);
        chk("d7_fifth_commit", pulse_cnt - p0, 8'd1);
        probe(1'b0, 3'b000);
        chk("prg1b_map", {4'h0, prg_a}, 8'h0B);
        chk("prg1b_wram", {7'h0, wram_dis}, 8'h01);

        // Back-to-back writes d0=1 then d0=0, followed by normal bits 0,1,1,0
        p0 = pulse_cnt;
        wr_cyc(2'd3, 1'b1, 1'b0);
        wr_cyc(2'd3, 1'b0, 1'b0);
        rd_cyc();
        wr(2'd3, 1'b0, 1'b0);
        wr(2'd3, 1'b1, 1'b0);
        wr(2'd3, 1'b1, 1'b0);
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
        chk("filt_three_no_commit", pulse_cnt - p0, 8'd0);
        wr(2'd3, 1'b0, 1'b0);
        chk("filt_commit", pulse_cnt - p0, 8'd1);
        probe(1'b0, 3'b000);
        chk("filt_prg", {4'h0, prg_a}, 8'h0D);
        chk("filt_wram", {7'h0, wram_dis}, 8'h00);
`else
        chk("nofilt_commit", pulse_cnt - p0, 8'd1);
        probe(1'b0, 3'b000);
        chk("nofilt_prg", {4'h0, prg_a}, 8'h09);
        chk("nofilt_wram", {7'h0, wram_dis}, 8'h01);
        wr(2'd3, 1'b0, 1'b0);
`endif
        wr(2'd0, 1'b0, 1'b1);

        // Reset after four writes, then a single write
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++)
            wr(2'd3, 1'b1, 1'b0);
        do_reset();
        wr(2'd3, 1'b1, 1'b0);
        chk("midrst_no_commit", pulse_cnt - p0, 8'd0);
        probe(1'b0, 3'b111);
        chk("midrst_prg", {4'h0, prg_a}, 8'h00);
        chk("midrst_wram", {7'h0, wram_dis}, 8'h00);
        chk("midrst_chr", {3'h0, chr_a}, 8'h01);
        chk("midrst_ciram", {7'h0, ciram_a10}, 8'h00);

        // cpu_wr without cpu_cyc must not shift; four more writes complete 09
        @(negedge ck);
        cpu_wr = 1'b1; cpu_d0 = 1'b1;
        repeat (3) @(negedge ck);
        cpu_wr = 1'b0;
        wr(2'd3, 1'b0, 1'b0);
        wr(2'd3, 1'b0, 1'b0);
        wr(2'd3, 1'b1, 1'b0);
        chk("stray_no_commit", pulse_cnt - p0, 8'd0);
        wr(2'd3, 1'b0, 1'b0);
        chk("stray_commit", pulse_cnt - p0, 8'd1);
        probe(1'b0, 3'b000);
        chk("stray_prg", {4'h0, prg_a}, 8'h09);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
